// File: rtl/rd_empty_gen_pkg.sv
//------------------------------------------------------------------------------
// Module      : rd_empty_gen_pkg
// Description : Shared asynchronous-FIFO helpers: pointer-width rule and
//               binary/Gray conversions. The conversions work on a 32-bit
//               container and are width-agnostic for zero-extended inputs,
//               so callers size-cast the result down to their pointer width.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rd_empty_gen_pkg;

    localparam int GRAY_MAXW = 32;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addrw);
        return addrw + 1;
    endfunction

    function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
        logic [GRAY_MAXW-1:0] b;
        b = '0;
        for (int i = 0; i < GRAY_MAXW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rd_empty_gen_ptr_sync.sv
//------------------------------------------------------------------------------
// Module      : ptr_sync
// Description : STAGES-deep flop chain for bringing a Gray-coded pointer into
//               another clock domain. No logic between stages.
//   clk   in   destination clock
//   rst_n in   asynchronous active-low reset, chain clears to 0
//   d     in   WIDTH  asynchronous Gray pointer
//   q     out  WIDTH  synchronized pointer
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ptr_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Index 0 is the first (metastability-exposed) stage.
    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rd_empty_gen.sv
//------------------------------------------------------------------------------
// Module      : rd_empty_gen
// Description : Read-domain status for the async FIFO. Synchronizes the Gray
//               write pointer into rclk and produces registered empty,
//               almost_empty, fill level and the Gray read pointer returned
//               to the write domain.
//   rclk         in   read clock
//   rst_n        in   asynchronous active-low reset
//   rd_en        in   raw read request
//   rptr         in   RD_ADDRW+1  binary read pointer (controller register)
//   wptr_gray    in   RD_ADDRW+1  Gray write pointer, asynchronous
//   rptr_gray    out  RD_ADDRW+1  registered Gray read pointer
//   empty        out  registered empty flag
//   almost_empty out  registered, level <= AE_THRESH
//   rd_level     out  RD_ADDRW+1  registered fill level, 0..2^RD_ADDRW
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rd_empty_gen
    import rd_empty_gen_pkg::*;
#(
    parameter int RD_ADDRW    = 5,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic              rclk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [RD_ADDRW:0] rptr,
    input  logic [RD_ADDRW:0] wptr_gray,
    output logic [RD_ADDRW:0] rptr_gray,
    output logic              empty,
    output logic              almost_empty,
    output logic [RD_ADDRW:0] rd_level
);

    localparam int PTRW = ptr_width(RD_ADDRW);
    localparam logic [PTRW-1:0] c_ae_thresh = PTRW'(AE_THRESH);

    logic [PTRW-1:0] w_wq_gray;
    logic [PTRW-1:0] w_wq_bin;
    logic            w_rd_inc;
    logic [PTRW-1:0] w_rptr_next;
    logic [PTRW-1:0] w_rptr_next_gray;
    logic [PTRW-1:0] w_level_next;

    ptr_sync #(
        .WIDTH  (PTRW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rst_n),
        .d     (wptr_gray),
        .q     (w_wq_gray)
    );

    // Same gating as the read address controller, so rptr_gray tracks rptr
    // with no extra latency and a read while empty never moves anything.
    assign w_rd_inc         = rd_en & ~empty;
    assign w_rptr_next      = rptr + {{(PTRW-1){1'b0}}, w_rd_inc};
    assign w_rptr_next_gray = PTRW'(bin2gray(GRAY_MAXW'(w_rptr_next)));
    assign w_wq_bin         = PTRW'(gray2bin(GRAY_MAXW'(w_wq_gray)));
    // Modulo subtraction; the wrap bit makes a full FIFO read as 2^RD_ADDRW.
    assign w_level_next     = w_wq_bin - w_rptr_next;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_gray    <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
        end else begin
            rptr_gray    <= w_rptr_next_gray;
            empty        <= (w_rptr_next_gray == w_wq_gray);
            almost_empty <= (w_level_next <= c_ae_thresh);
            rd_level     <= w_level_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rd_empty_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_rd_empty_gen
// Description : Self-checking bench for rd_empty_gen. The bench acts as the
//               read address controller and write side; a queue-based model
//               delays the write pointer by the synchronizer depth and derives
//               level/flags from pointer arithmetic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rd_empty_gen;

    localparam int RD_ADDRW    = 5;
    localparam int SYNC_STAGES = 2;
    localparam int AE_THRESH   = 2;
    localparam int DEPTH       = 1 << RD_ADDRW;
    localparam int MODV        = 2 * DEPTH;

    logic              rclk;
    logic              rst_n;
    logic              rd_en;
    logic [RD_ADDRW:0] rptr;
    logic [RD_ADDRW:0] wptr_gray;
    logic [RD_ADDRW:0] rptr_gray;
    logic              empty;
    logic              almost_empty;
    logic [RD_ADDRW:0] rd_level;

    rd_empty_gen #(
        .RD_ADDRW    (RD_ADDRW),
        .SYNC_STAGES (SYNC_STAGES),
        .AE_THRESH   (AE_THRESH)
    ) dut (
        .rclk         (rclk),
        .rst_n        (rst_n),
        .rd_en        (rd_en),
        .rptr         (rptr),
        .wptr_gray    (wptr_gray),
        .rptr_gray    (rptr_gray),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: write pointer (binary), read pointer (binary), the
    // write-pointer values still in flight to the read domain, and the
    // last predicted empty flag.
    int  m_w;
    int  m_r;
    int  m_wq[$];
    bit  m_empty;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) & (MODV - 1);
    endfunction

    task automatic model_reset();
        m_wq.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_wq.push_back(0);
        m_empty = 1'b1;
        m_r     = 0;
    endtask

    // One rclk cycle: drive inputs, clock, update model, check all outputs.
    task automatic step(input bit ren);
        int seen, inc, rnext, lvl;
        rd_en     = ren;
        rptr      = m_r[RD_ADDRW:0];
        wptr_gray = gray_of(m_w);
        @(posedge rclk);
        seen = m_wq.pop_front();
        m_wq.push_back(m_w);
        inc     = (ren && !m_empty) ? 1 : 0;
        rnext   = (m_r + inc) % MODV;
        lvl     = (seen - rnext + MODV) % MODV;
        m_empty = (lvl == 0);
        #1;
        check("rptr_gray", int'(rptr_gray), gray_of(rnext));
        check("empty", int'(empty), int'(m_empty));
        check("almost_empty", int'(almost_empty), (lvl <= AE_THRESH) ? 1 : 0);
        check("rd_level", int'(rd_level), lvl);
        m_r  = rnext;
        rptr = m_r[RD_ADDRW:0];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rptr_gray"}, int'(rptr_gray), 0);
        check({tag, "_empty"}, int'(empty), 1);
        check({tag, "_almost_empty"}, int'(almost_empty), 1);
        check({tag, "_rd_level"}, int'(rd_level), 0);
    endtask

    initial begin
        rst_n     = 1'b1;
        rd_en     = 1'b0;
        rptr      = '0;
        wptr_gray = '0;
        m_w       = 0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge rclk);
        #3 rst_n = 1'b1;

        // Write arrival: empty falls on the 3rd edge after the change.
        m_w = 1;
        step(0);
        step(0);
        check("arrive_edge2_empty", int'(empty), 1);
        step(0);
        check("arrive_edge3_empty", int'(empty), 0);
        check("arrive_level", int'(rd_level), 1);
        check("arrive_ae", int'(almost_empty), 1);

        // Drain with rd_en held: exactly one increment.
        step(1);
        check("drain_rptr_gray", int'(rptr_gray), 1);
        check("drain_empty", int'(empty), 1);
        step(1);
        step(1);
        check("drain_hold_rptr_gray", int'(rptr_gray), 1);
        check("drain_hold_rptr", m_r, 1);

        // Wrap: rptr=31, wptr=32, one read.
        m_r = 31;
        m_w = 32;
        repeat (3) step(0);
        check("wrap_pre_level", int'(rd_level), 1);
        step(1);
        check("wrap_rptr_gray", int'(rptr_gray), 6'b110000);
        check("wrap_empty", int'(empty), 1);
        check("wrap_level", int'(rd_level), 0);

        // Full: rptr=0, wptr=32.
        m_r = 0;
        m_w = 32;
        repeat (3) step(0);
        check("full_level", int'(rd_level), 32);
        check("full_empty", int'(empty), 0);
        check("full_ae", int'(almost_empty), 0);

        // Threshold: level 3 then one read drops to 2.
        m_r = 0;
        m_w = 3;
        repeat (3) step(0);
        check("thr3_ae", int'(almost_empty), 0);
        step(1);
        check("thr2_level", int'(rd_level), 2);
        check("thr2_ae", int'(almost_empty), 1);
        // Back to 3, then concurrent read and write increment.
        m_w = 4;
        repeat (3) step(0);
        check("conc_pre_level", int'(rd_level), 3);
        m_w = 5;
        step(1);
        repeat (2) step(0);
        check("conc_level", int'(rd_level), 3);

        // Mid-stream asynchronous reset with wptr_gray = 000011.
        m_r = 0;
        m_w = 2;
        repeat (3) step(1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid");
        check("mid_wptr_gray_in", int'(wptr_gray), 3);
        repeat (2) @(posedge rclk);
        #3 rst_n = 1'b1;
        model_reset();
        repeat (4) step(0);
        check("post_reset_level", int'(rd_level), 2);

        // Randomized traffic, keeping the writer within FIFO capacity.
        for (int i = 0; i < 600; i++) begin
            if (($urandom % 2) == 1 && ((m_w - m_r + MODV) % MODV) < DEPTH)
                m_w = (m_w + 1) % MODV;
            step(($urandom % 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
